// File: rtl/dbus_responder.sv
// Data-bus responder: a fixed-latency memory model behind a valid/ok handshake.
// Holds one request at a time, answers LATENCY cycles after acceptance with the
// old word at the addressed index, and applies byte-strobed writes at the RESP edge.

typedef enum logic [1:0] {
  MSIZE1,
  MSIZE2,
  MSIZE4,
  MSIZE8
} msize_t;

typedef struct packed {
  logic        valid;
  logic [63:0] addr;
  msize_t      size;
  logic [7:0]  strobe;
  logic [63:0] data;
} dbus_req_t;

typedef struct packed {
  logic        addr_ok;
  logic        data_ok;
  logic [63:0] data;
} dbus_resp_t;

module dbus_responder #(
  parameter int unsigned INDEX_BITS = 12,
  parameter int unsigned LATENCY    = 2,
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000
) (
  input  logic       clk,
  input  logic       rst,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       fault,
  output logic       busy
);

  localparam int unsigned Words     = 2 ** INDEX_BITS;
  localparam logic [63:0] SpanBytes = 64'd8 << INDEX_BITS;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  state_e                  state_q, state_d;
  logic      [3:0]         cnt_q, cnt_d;
  dbus_req_t               req_q, req_d;

  logic      [63:0]        mem [Words];

  logic      [63:0]        off;
  logic [INDEX_BITS-1:0]   idx;
  logic                    in_range;
  logic                    aligned;
  logic                    access_ok;
  logic                    do_write;
  logic                    unused_bits;

  // State, countdown and latched request; reset aborts any request in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  // Next-state: accept only in IDLE, count down in WAIT, RESP lasts one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    unique case (state_q)
      StIdle: begin
        if (dreq.valid) begin
          req_d   = dreq;
          cnt_d   = 4'(LATENCY - 1);
          state_d = (LATENCY == 1) ? StResp : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        // Leave on the cycle the count reaches zero so RESP lands LATENCY after accept.
        if (cnt_q <= 4'd1) begin
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign off      = req_q.addr - BASE_ADDR;
  assign idx      = off[INDEX_BITS+2:3];
  assign in_range = off < SpanBytes;

  // Natural alignment check on the latched size.
  always_comb begin
    aligned = 1'b0;
    unique case (req_q.size)
      MSIZE1:  aligned = 1'b1;
      MSIZE2:  aligned = ~req_q.addr[0];
      MSIZE4:  aligned = ~|req_q.addr[1:0];
      MSIZE8:  aligned = ~|req_q.addr[2:0];
      default: aligned = 1'b0;
    endcase
  end

  assign access_ok = in_range & aligned;
  assign do_write  = (state_q == StResp) & access_ok & (|req_q.strobe);

  // Response outputs decode straight from state so reset clears them at once.
  always_comb begin
    dresp = '0;
    fault = 1'b0;
    busy  = (state_q != StIdle);
    if (state_q == StResp) begin
      dresp.addr_ok = 1'b1;
      dresp.data_ok = 1'b1;
      dresp.data    = access_ok ? mem[idx] : 64'd0;
      fault         = ~access_ok;
    end
  end

  // Byte-lane write at the RESP edge; the response above still shows the old word.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 8; i++) begin
        if (req_q.strobe[i]) begin
          mem[idx][8*i +: 8] <= req_q.data[8*i +: 8];
        end
      end
    end
  end

  assign unused_bits = ^{off[63:INDEX_BITS+3], off[2:0], req_q.valid};

endmodule

// File: tb/tb_dbus_responder.sv
// Directed bench for dbus_responder: timing, strobes, faults, hold-off and reset abort.

module tb_dbus_responder;

  localparam int unsigned Lat = 2;

  logic       clk = 1'b0;
  logic       rst;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  logic       fault;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dbus_responder #(
    .INDEX_BITS(12),
    .LATENCY   (Lat),
    .BASE_ADDR (64'h8000_0000)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .dreq (dreq),
    .dresp(dresp),
    .fault(fault),
    .busy (busy)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "/addr_ok"}, 64'(dresp.addr_ok), 64'd0);
    check_val({tag, "/data_ok"}, 64'(dresp.data_ok), 64'd0);
    check_val({tag, "/data"}, dresp.data, 64'd0);
    check_val({tag, "/fault"}, 64'(fault), 64'd0);
    check_val({tag, "/busy"}, 64'(busy), 64'd0);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the following idle cycle.
  task automatic run_req(input string tag, input logic [63:0] addr, input msize_t size,
                         input logic [7:0] strb, input logic [63:0] wdata, input bit chk_data,
                         input logic [63:0] exp_data, input logic exp_fault, input bit scramble);
    int n;
    bit seen;
    dreq.valid  = 1'b1;
    dreq.addr   = addr;
    dreq.size   = size;
    dreq.strobe = strb;
    dreq.data   = wdata;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 16) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check_val({tag, "/busy_wait"}, 64'(busy), 64'd1);
        if (scramble) begin
          dreq.valid  = 1'b0;
          dreq.addr   = addr + 64'd8;
          dreq.strobe = 8'h00;
          dreq.data   = ~wdata;
        end
      end
      if (dresp.addr_ok) seen = 1'b1;
    end
    check_val({tag, "/latency"}, 64'(n), 64'(Lat));
    check_val({tag, "/data_ok"}, 64'(dresp.data_ok), 64'd1);
    check_val({tag, "/fault"}, 64'(fault), 64'(exp_fault));
    if (chk_data) check_val({tag, "/data"}, dresp.data, exp_data);
    // Request is still held through the RESP edge; it must not be taken a second time.
    @(posedge clk);
    #1;
    dreq.valid = 1'b0;
    @(negedge clk);
    check_quiet({tag, "/idle"});
  endtask

  // Full-word write of zero to 8000_0010, aborted by reset in WAIT or in RESP.
  task automatic reset_mid(input string tag, input bit in_resp);
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h8000_0010;
    dreq.size   = MSIZE8;
    dreq.strobe = 8'hFF;
    dreq.data   = 64'd0;
    @(negedge clk);
    if (in_resp) begin
      @(negedge clk);
      check_val({tag, "/pre_ok"}, 64'(dresp.addr_ok), 64'd1);
    end
    check_val({tag, "/pre_busy"}, 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    check_quiet({tag, "/async"});
    @(posedge clk);
    #1;
    check_val({tag, "/held_busy"}, 64'(busy), 64'd0);
    @(negedge clk);
    rst        = 1'b1;
    dreq.valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst  = 1'b0;
    dreq = '0;
    @(posedge clk);
    #1;
    check_quiet("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Full-word write then read back.
    run_req("wr_full", 64'h8000_0010, MSIZE8, 8'hFF, 64'h1122_3344_5566_7788, 1'b0, 64'd0, 1'b0,
            1'b0);
    run_req("rd_full", 64'h8000_0010, MSIZE8, 8'h00, 64'd0, 1'b1, 64'h1122_3344_5566_7788, 1'b0,
            1'b0);

    // Partial strobe: response carries old word, low four lanes cleared afterwards.
    run_req("pre_ones", 64'h8000_0020, MSIZE8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0, 1'b0,
            1'b0);
    run_req("wr_part", 64'h8000_0020, MSIZE8, 8'h0F, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
            1'b0);
    run_req("rd_part", 64'h8000_0020, MSIZE8, 8'h00, 64'd0, 1'b1, 64'hFFFF_FFFF_0000_0000, 1'b0,
            1'b0);

    // Range and alignment faults.
    run_req("rd_below", 64'h7FFF_FFF8, MSIZE8, 8'h00, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0);
    run_req("pre_w0", 64'h8000_0000, MSIZE8, 8'hFF, 64'hA5A5_A5A5_5A5A_5A5A, 1'b0, 64'd0, 1'b0,
            1'b0);
    run_req("wr_mis4", 64'h8000_0002, MSIZE4, 8'h0F, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0);
    run_req("rd_w0", 64'h8000_0000, MSIZE8, 8'h00, 64'd0, 1'b1, 64'hA5A5_A5A5_5A5A_5A5A, 1'b0,
            1'b0);
    run_req("rd_al2", 64'h8000_0002, MSIZE2, 8'h00, 64'd0, 1'b1, 64'hA5A5_A5A5_5A5A_5A5A, 1'b0,
            1'b0);
    run_req("rd_mis8", 64'h8000_0004, MSIZE8, 8'h00, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0);
    run_req("wr_last", 64'h8000_7FF8, MSIZE8, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0, 64'd0, 1'b0,
            1'b0);
    run_req("rd_last", 64'h8000_7FF8, MSIZE8, 8'h00, 64'd0, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0,
            1'b0);
    run_req("rd_above", 64'h8000_8000, MSIZE8, 8'h00, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0);

    // AMO-style pair: write reissued in the first idle cycle after the read response.
    run_req("amo_rd", 64'h8000_0010, MSIZE8, 8'h00, 64'd0, 1'b1, 64'h1122_3344_5566_7788, 1'b0,
            1'b0);
    run_req("amo_wr", 64'h8000_0010, MSIZE8, 8'hF0, 64'hCAFE_BABE_0000_0000, 1'b1,
            64'h1122_3344_5566_7788, 1'b0, 1'b0);
    run_req("amo_chk", 64'h8000_0010, MSIZE8, 8'h00, 64'd0, 1'b1, 64'hCAFE_BABE_5566_7788, 1'b0,
            1'b0);

    // Request fields changing (and valid dropping) after acceptance are ignored.
    run_req("wr_scr", 64'h8000_0030, MSIZE8, 8'hFF, 64'h0F0E_0D0C_0B0A_0908, 1'b0, 64'd0, 1'b0,
            1'b1);
    run_req("rd_scr", 64'h8000_0030, MSIZE8, 8'h00, 64'd0, 1'b1, 64'h0F0E_0D0C_0B0A_0908, 1'b0,
            1'b0);

    // Reset aborts a pending write in WAIT and in RESP; the old word survives.
    reset_mid("rst_wait", 1'b0);
    run_req("rd_rst_w", 64'h8000_0010, MSIZE8, 8'h00, 64'd0, 1'b1, 64'hCAFE_BABE_5566_7788, 1'b0,
            1'b0);
    reset_mid("rst_resp", 1'b1);
    run_req("rd_rst_r", 64'h8000_0010, MSIZE8, 8'h00, 64'd0, 1'b1, 64'hCAFE_BABE_5566_7788, 1'b0,
            1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dbus_responder.md
DBUS_RESPONDER -- requirements
Module: dbus_responder

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 12, meaning backing store holds 2^INDEX_BITS 64-bit words.
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to response; legal range 1..15.
REQ-003 SHALL have parameter BASE_ADDR, default 64'h8000_0000, meaning byte address of word 0.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 dreq  input  dbus_req_t  request from initiator: valid, addr (64), size (msize_t), strobe (8), data (64).
REQ-007 dresp  output  dbus_resp_t  response: addr_ok, data_ok, data (64).
REQ-008 fault  output  1  one-cycle pulse, coincident with the response, flagging an out-of-range or misaligned access.
REQ-009 busy  output  1  high while a request is held (ACCEPT through RESP).

Function
REQ-010 SHALL implement states IDLE, WAIT, RESP.
REQ-011 In IDLE with dreq.valid=1, SHALL latch addr, size, strobe and data, load the counter with LATENCY-1, and go to WAIT, or to RESP when LATENCY=1.
REQ-012 In WAIT, SHALL decrement the counter each cycle and go to RESP on the cycle the counter is 0.
REQ-013 Response timing: addr_ok and data_ok SHALL both be high, together, for exactly one cycle, LATENCY cycles after the cycle in which valid was first sampled in IDLE.
REQ-014 RESP SHALL always go to IDLE next cycle. A request SHALL NOT be accepted in RESP or WAIT, since the initiator still holds the old request during RESP.
REQ-015 After deasserting addr_ok/data_ok for one IDLE cycle, SHALL accept a new request. Back-to-back request spacing is LATENCY+1 cycles (the AMO read-then-write pair case).
REQ-016 All decisions SHALL use the latched request. Changes to dreq after acceptance, including valid dropping in WAIT, SHALL be ignored until IDLE.
REQ-017 Word index SHALL be (addr-BASE_ADDR)[INDEX_BITS+2:3]. The access is in range iff addr-BASE_ADDR < 8*2^INDEX_BITS, unsigned 64-bit compare.
REQ-018 Alignment: size MSIZE1/2/4/8 requires addr low 0/1/2/3 bits zero; otherwise the access is misaligned.
REQ-019 dresp.data SHALL be the full 64-bit word at the index as it was before any write of this request (old data), with no byte shifting; the initiator extracts lanes.
REQ-020 Write: strobe != 0 marks a write. At the RESP clock edge, byte lane i (data[8i+7:8i]) SHALL be written iff strobe[i]=1. Other lanes SHALL be unchanged.
REQ-021 strobe = 0 SHALL be a pure read with no store update.
REQ-022 Out-of-range or misaligned access: SHALL still respond with normal timing, with dresp.data=0, no store update, and fault=1 in the RESP cycle.
REQ-023 Outside RESP: dresp.addr_ok=0, dresp.data_ok=0, dresp.data=0, fault=0.
REQ-024 busy SHALL be 1 in WAIT and RESP, and 0 in IDLE.
REQ-025 Counter width SHALL be 4 bits; no wrap is possible within the legal LATENCY range.

Reset
REQ-026 rst=0 SHALL immediately, without waiting for a clock, force IDLE, counter=0, addr_ok=0, data_ok=0, dresp.data=0, fault=0 and busy=0.
REQ-027 Reset during WAIT or RESP SHALL abort the request. A write whose RESP edge has not yet occurred SHALL NOT modify the store.
REQ-028 Store contents SHALL NOT be cleared by reset; contents before the first write are undefined to the bench except where preloaded.
REQ-029 The first acceptance after rst rises SHALL occur no earlier than the first rising edge sampled with rst=1.

Verification
REQ-030 Full-word write then read: LATENCY=2; write addr 8000_0010, strobe FF, data 1122334455667788; response 2 cycles after accept; then read the same address -> dresp.data=1122334455667788, fault=0.
REQ-031 Partial strobe: word preloaded FFFF_FFFF_FFFF_FFFF; write strobe 0F, data 0 -> subsequent read returns FFFF_FFFF_0000_0000, and the write's own response data is FFFF_FFFF_FFFF_FFFF.
REQ-032 Out-of-range and misaligned: read addr 7FFF_FFF8 -> data 0, fault pulse. MSIZE4 write at 8000_0002 -> fault pulse, store unchanged.
REQ-033 Back-to-back AMO-style access: initiator reissues a write in the cycle after the read response -> accepted in IDLE, second response LATENCY cycles later, ok signals low for exactly one cycle between responses.
REQ-034 Hold-off: valid stays high through RESP with the old request -> exactly one response per request; no duplicate acceptance.
REQ-035 Reset mid-write: assert rst=0 in WAIT of a strobe FF write -> outputs 0 immediately, state IDLE; a later read shows the old word.
